// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcodes, FSM states,
// ALU select codes and the ALU/immediate helpers.
package cpu_pkg;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0f;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    ST_RST, ST_IF, ST_EX, ST_MEM, ST_WB, ST_HALT, ST_ERR
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  function automatic logic [31:0] alu(alu_op_t op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

  function automatic logic [31:0] decode_imm(logic [31:0] ir);
    case (ir[6:0])
      OP_LUI, OP_AUIPC: return {ir[31:12], 12'h000};
      OP_JAL:           return {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      OP_BRANCH:        return {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_STORE:         return {{21{ir[31]}}, ir[30:25], ir[11:7]};
      default:          return {{21{ir[31]}}, ir[30:20]};
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane handling for the data port: store lane replication and mask,
// load lane extract with sign/zero extension, and the misalignment flag.
module lsu_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    misalign = (funct3[1:0] == 2'd1 && addr_lo[0]) ||
               (funct3[1:0] == 2'd2 && addr_lo != 2'd0);
    shifted  = load_word >> {addr_lo, 3'b000};
    case (funct3[1:0])
      2'd0: begin
        wdata = {4{store_data[7:0]}};
        wmask = 4'b0001 << addr_lo;
      end
      2'd1: begin
        wdata = {2{store_data[15:0]}};
        wmask = 4'b0011 << addr_lo;
      end
      default: begin
        wdata = store_data;
        wmask = 4'b1111;
      end
    endcase
    case (funct3)
      3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_data = {24'b0, shifted[7:0]};
      3'd5:    load_data = {16'b0, shifted[15:0]};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32I core sequenced IF/EX/MEM/WB, with req/ack instruction and
// data ports, bus timeout, EBREAK halt and sticky error trapping.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halt,
  output logic        err
);

  localparam int unsigned RW        = $clog2(NREGS);
  localparam logic [5:0]  NREGS_W   = 6'(NREGS);
  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  state_t      state, state_nx;
  logic [31:0] ir, dnpc_q, rd_val;
  logic        rd_wen;
  logic [15:0] wait_cnt;
  logic [31:0] regs [NREGS];

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd_idx, rs1_idx, rs2_idx;
  logic [31:0] rs1_v, rs2_v, imm, ea, alu_b, result, dnpc;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wmask;
  logic        illegal, has_rd, use_rs1, use_rs2, is_mem, is_store, ebreak, misalign, fault;
  alu_op_t     alu_op;

  assign opcode  = ir[6:0];
  assign f3      = ir[14:12];
  assign f7      = ir[31:25];
  assign rd_idx  = ir[11:7];
  assign rs1_idx = ir[19:15];
  assign rs2_idx = ir[24:20];
  assign rs1_v   = (rs1_idx == 5'd0) ? '0 : regs[rs1_idx[RW-1:0]];
  assign rs2_v   = (rs2_idx == 5'd0) ? '0 : regs[rs2_idx[RW-1:0]];
  assign imm     = decode_imm(ir);
  assign ea      = rs1_v + imm;

  // ir and the register file are frozen through MEM, so ea still addresses the load lane there
  lsu_align u_lsu (
    .funct3     (f3),
    .addr_lo    (ea[1:0]),
    .store_data (rs2_v),
    .load_word  (dmem_rdata),
    .wdata      (st_wdata),
    .wmask      (st_wmask),
    .load_data  (ld_data),
    .misalign   (misalign)
  );

  always_comb begin
    illegal = 1'b0; has_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    is_mem = 1'b0; is_store = 1'b0; ebreak = 1'b0;
    alu_b = imm; result = '0; dnpc = pc + 32'd4;
    case (f3)
      3'd0:    alu_op = (opcode == OP_REG && f7[5]) ? ALU_SUB : ALU_ADD;
      3'd1:    alu_op = ALU_SLL;
      3'd2:    alu_op = ALU_SLT;
      3'd3:    alu_op = ALU_SLTU;
      3'd4:    alu_op = ALU_XOR;
      3'd5:    alu_op = f7[5] ? ALU_SRA : ALU_SRL;
      3'd6:    alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
    case (opcode)
      OP_LUI:   begin has_rd = 1'b1; result = imm; end
      OP_AUIPC: begin has_rd = 1'b1; result = pc + imm; end
      OP_JAL:   begin has_rd = 1'b1; result = pc + 32'd4; dnpc = pc + imm; end
      OP_JALR: begin
        has_rd = 1'b1; use_rs1 = 1'b1; illegal = (f3 != 3'd0);
        result = pc + 32'd4; dnpc = {ea[31:1], 1'b0};
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'd0: if (rs1_v == rs2_v) dnpc = pc + imm;
          3'd1: if (rs1_v != rs2_v) dnpc = pc + imm;
          3'd4: if ($signed(rs1_v) < $signed(rs2_v)) dnpc = pc + imm;
          3'd5: if ($signed(rs1_v) >= $signed(rs2_v)) dnpc = pc + imm;
          3'd6: if (rs1_v < rs2_v) dnpc = pc + imm;
          3'd7: if (rs1_v >= rs2_v) dnpc = pc + imm;
          default: illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        has_rd = 1'b1; use_rs1 = 1'b1; is_mem = 1'b1;
        illegal = (f3 == 3'd3) || (f3 >= 3'd6);
      end
      OP_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; is_mem = 1'b1; is_store = 1'b1;
        illegal = (f3 > 3'd2);
      end
      OP_IMM: begin
        has_rd = 1'b1; use_rs1 = 1'b1; result = alu(alu_op, rs1_v, alu_b);
        illegal = (f3 == 3'd1 && f7 != 7'h00) ||
                  (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      OP_REG: begin
        has_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; alu_b = rs2_v;
        result = alu(alu_op, rs1_v, alu_b);
        illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OP_FENCE: ;
      OP_SYSTEM: begin
        if (ir == INSN_EBREAK) ebreak = 1'b1;
        else if (ir != INSN_ECALL) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if ((has_rd && {1'b0, rd_idx} >= NREGS_W) || (use_rs1 && {1'b0, rs1_idx} >= NREGS_W) ||
        (use_rs2 && {1'b0, rs2_idx} >= NREGS_W))
      illegal = 1'b1;
    fault = illegal || dnpc[1] || (is_mem && misalign);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RST;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_RST: state_nx = ST_IF;
      ST_IF:  if (imem_ack) state_nx = ST_EX;
              else if (wait_cnt == WAIT_LAST) state_nx = ST_ERR;
      ST_EX:  if (fault) state_nx = ST_ERR;
              else if (ebreak) state_nx = ST_HALT;
              else if (is_mem) state_nx = ST_MEM;
              else state_nx = ST_WB;
      ST_MEM: if (dmem_ack) state_nx = ST_WB;
              else if (wait_cnt == WAIT_LAST) state_nx = ST_ERR;
      ST_WB:  state_nx = ST_IF;
      default: state_nx = state;
    endcase
  end

  always_comb begin
    imem_req  = (state == ST_IF);
    dmem_req  = (state == ST_MEM);
    retire    = (state == ST_WB);
    halt      = (state == ST_HALT);
    err       = (state == ST_ERR);
    imem_addr = pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC; ir <= '0; dnpc_q <= '0; rd_val <= '0; rd_wen <= 1'b0; wait_cnt <= '0;
      dmem_we <= 1'b0; dmem_addr <= '0; dmem_wdata <= '0; dmem_wmask <= '0;
    end else begin
      if (state_nx != state) wait_cnt <= '0;
      else if (imem_req || dmem_req) wait_cnt <= wait_cnt + 16'd1;
      if (state == ST_IF && imem_ack) ir <= imem_rdata;
      if (state == ST_EX) begin
        dnpc_q     <= dnpc;
        rd_val     <= result;
        rd_wen     <= has_rd && (rd_idx != 5'd0);
        dmem_we    <= is_store;
        dmem_addr  <= ea;
        dmem_wdata <= st_wdata;
        dmem_wmask <= is_store ? st_wmask : '0;
      end
      if (state == ST_MEM && dmem_ack && !dmem_we) rd_val <= ld_data;
      if (state == ST_WB) pc <= dnpc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_WB && rd_wen) regs[rd_idx[RW-1:0]] <= rd_val;
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: small programs against simple
// req/ack memory models with configurable wait states.
module tb_cpu_multicycle;

  localparam logic [31:0] RPC    = 32'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk, rst;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halt, err;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;
  logic [3:0]  dmem_wmask;

  logic [31:0] imem [128];
  logic [31:0] dmem [256];
  logic        imem_en, dmem_clear;
  int          imem_wait, dmem_wait, icnt, dcnt;
  int          retire_cnt, dmem_cnt;
  logic        last_we;
  logic [3:0]  last_mask;
  logic [31:0] last_addr, last_wdata;
  int          errors, checks;

  cpu_multicycle #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .retire(retire), .halt(halt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_ack   = imem_req && imem_en && (icnt == imem_wait);
  assign imem_rdata = imem[imem_addr[8:2]];
  assign dmem_ack   = dmem_req && (dcnt == dmem_wait);
  assign dmem_rdata = dmem[dmem_addr[9:2]];

  always @(posedge clk) begin
    icnt <= (!imem_req || imem_ack) ? 0 : icnt + 1;
    dcnt <= (!dmem_req || dmem_ack) ? 0 : dcnt + 1;
    if (dmem_clear) begin
      for (int i = 0; i < 256; i++) dmem[i] <= '0;
    end else if (dmem_req && dmem_ack && dmem_we) begin
      for (int b = 0; b < 4; b++)
        if (dmem_wmask[b]) dmem[dmem_addr[9:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
    end
  end

  initial begin retire_cnt = 0; dmem_cnt = 0; end
  always @(negedge clk) begin
    if (retire) retire_cnt <= retire_cnt + 1;
    if (dmem_req) begin
      dmem_cnt   <= dmem_cnt + 1;
      last_we    <= dmem_we;
      last_mask  <= dmem_wmask;
      last_addr  <= dmem_addr;
      last_wdata <= dmem_wdata;
    end
  end

  function automatic logic [31:0] enc_i(logic [6:0] op, logic [2:0] f3, logic [4:0] rd,
                                        logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2,
                                        logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2,
                                        logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(logic [6:0] op, logic [4:0] rd, logic [19:0] imm);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [4:0] rd, logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 128; i++) imem[i] = EBREAK;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    dmem_clear = 1'b1;
    repeat (2) @(negedge clk);
    dmem_clear = 1'b0;
    rst = 1'b1;
  endtask

  task automatic wait_fetch(input string tag, input logic [31:0] a, output int n);
    logic found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      n++;
      if (imem_req && imem_addr == a) found = 1'b1;
    end
    check(tag, {31'b0, found}, 32'd1);
  endtask

  task automatic next_fetch(input string tag, output logic [31:0] a);
    logic found;
    found = 1'b0;
    a = '0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (imem_req) begin found = 1'b1; a = imem_addr; end
    end
    check(tag, {31'b0, found}, 32'd1);
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 400 && !halt && !err; i++) step();
    check(tag, {31'b0, halt}, 32'd1);
  endtask

  int          n, rbase, dbase;
  logic [31:0] fa;

  initial begin
    errors = 0; checks = 0;
    rst = 1'b0; dmem_clear = 1'b1;
    imem_en = 1'b1; imem_wait = 0; dmem_wait = 0;

    // 1: ALU sequence with zero-wait memory, cycle-exact
    clear_prog();
    imem[0] = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'h005);
    imem[1] = enc_i(7'h13, 3'd0, 5'd2, 5'd1, 12'hFF9);
    imem[2] = enc_u(7'h37, 5'd3, 20'h80001);
    imem[3] = enc_s(3'd2, 5'd3, 5'd2, 12'h000);
    step(); step();
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("rst_flags", {29'b0, retire, halt, err}, 32'd0);
    check("rst_pc", pc, RPC);
    do_reset();
    step();
    check("t1_if0_req", {31'b0, imem_req}, 32'd1);
    check("t1_if0_addr", imem_addr, RPC);
    step();
    check("t1_ex_retire", {31'b0, retire}, 32'd0);
    step();
    check("t1_wb_retire", {31'b0, retire}, 32'd1);
    step();
    check("t1_if1_addr", imem_addr, 32'h8000_0004);
    check("t1_if1_retire", {31'b0, retire}, 32'd0);
    step(); step();
    check("t1_wb1_retire", {31'b0, retire}, 32'd1);
    wait_halt("t1_halt");
    check("t1_x2", dmem[0], 32'hFFFF_FFFE);
    check("t1_err", {31'b0, err}, 32'd0);
    check("t1_halt_pc", pc, 32'h8000_0010);

    // 2: stores and loads through a 2-wait-state data RAM
    clear_prog();
    imem[0]  = enc_u(7'h37, 5'd1, 20'h80001);
    imem[1]  = enc_u(7'h37, 5'd2, 20'h12345);
    imem[2]  = enc_i(7'h13, 3'd0, 5'd2, 5'd2, 12'h678);
    imem[3]  = enc_s(3'd2, 5'd1, 5'd2, 12'd0);
    imem[4]  = enc_i(7'h03, 3'd0, 5'd3, 5'd1, 12'd1);
    imem[5]  = enc_i(7'h03, 3'd4, 5'd4, 5'd1, 12'd3);
    imem[6]  = enc_s(3'd2, 5'd1, 5'd3, 12'd4);
    imem[7]  = enc_s(3'd2, 5'd1, 5'd4, 12'd8);
    imem[8]  = enc_s(3'd0, 5'd1, 5'd2, 12'd5);
    imem[9]  = enc_i(7'h13, 3'd0, 5'd5, 5'd0, 12'hF80);
    imem[10] = enc_s(3'd0, 5'd1, 5'd5, 12'd12);
    imem[11] = enc_i(7'h03, 3'd0, 5'd6, 5'd1, 12'd12);
    imem[12] = enc_s(3'd2, 5'd1, 5'd6, 12'd16);
    dmem_wait = 2;
    do_reset();
    wait_fetch("t2_fetch_sw", 32'h8000_000C, n);
    wait_fetch("t2_fetch_lb", 32'h8000_0010, n);
    check("t2_sw_cycles", n, 32'd6);
    check("t2_sw_we", {31'b0, last_we}, 32'd1);
    check("t2_sw_mask", {28'b0, last_mask}, 32'hF);
    check("t2_sw_addr", last_addr, 32'h8000_1000);
    check("t2_sw_wdata", last_wdata, 32'h1234_5678);
    wait_fetch("t2_fetch_lbu", 32'h8000_0014, n);
    check("t2_lb_cycles", n, 32'd6);
    check("t2_lb_we", {31'b0, last_we}, 32'd0);
    check("t2_lb_mask", {28'b0, last_mask}, 32'h0);
    check("t2_lb_addr", last_addr, 32'h8000_1001);
    wait_fetch("t2_fetch_after_sb", 32'h8000_0024, n);
    check("t2_sb_mask", {28'b0, last_mask}, 32'b0010);
    check("t2_sb_wdata", last_wdata, 32'h7878_7878);
    wait_halt("t2_halt");
    check("t2_mem0", dmem[0], 32'h1234_5678);
    check("t2_lb_merge", dmem[1], 32'h0000_7856);
    check("t2_lbu", dmem[2], 32'h0000_0012);
    check("t2_sb_neg", dmem[3], 32'h0000_0080);
    check("t2_lb_sext", dmem[4], 32'hFFFF_FF80);
    dmem_wait = 0;

    // 3: backward BEQ and JALR with bit0 of the target cleared
    clear_prog();
    imem[0]  = enc_u(7'h37, 5'd10, 20'h80001);
    imem[1]  = enc_i(7'h13, 3'd0, 5'd3, 5'd0, 12'd2);
    imem[2]  = enc_i(7'h13, 3'd0, 5'd2, 5'd0, 12'd1);
    imem[3]  = enc_i(7'h13, 3'd0, 5'd2, 5'd2, 12'd1);
    imem[4]  = enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd0);
    imem[5]  = enc_b(3'd0, 5'd2, 5'd3, 13'h1FF8);
    imem[6]  = enc_u(7'h37, 5'd4, 20'h80000);
    imem[7]  = enc_i(7'h67, 3'd0, 5'd5, 5'd4, 12'h101);
    imem[64] = enc_s(3'd2, 5'd10, 5'd5, 12'd0);
    imem[65] = enc_s(3'd2, 5'd10, 5'd2, 12'd4);
    do_reset();
    wait_fetch("t3_fetch_beq", 32'h8000_0014, n);
    next_fetch("t3_nf_beq", fa);
    check("t3_beq_target", fa, 32'h8000_000C);
    wait_fetch("t3_fetch_jalr", 32'h8000_001C, n);
    next_fetch("t3_nf_jalr", fa);
    check("t3_jalr_target", fa, 32'h8000_0100);
    wait_halt("t3_halt");
    check("t3_link", dmem[0], 32'h8000_0020);
    check("t3_loop_count", dmem[1], 32'd3);

    // 4: misaligned LW, misaligned JAL target, illegal opcode
    clear_prog();
    imem[0] = enc_u(7'h37, 5'd1, 20'h80001);
    imem[1] = enc_i(7'h03, 3'd2, 5'd2, 5'd1, 12'd2);
    do_reset();
    rbase = retire_cnt; dbase = dmem_cnt;
    wait_fetch("t4_fetch_lw", 32'h8000_0004, n);
    step(); step();
    check("t4_lw_err", {31'b0, err}, 32'd1);
    check("t4_lw_pc", pc, 32'h8000_0004);
    step(); step();
    check("t4_lw_no_dreq", dmem_cnt - dbase, 32'd0);
    check("t4_lw_retires", retire_cnt - rbase, 32'd1);
    check("t4_lw_reqs", {30'b0, imem_req, dmem_req}, 32'd0);
    clear_prog();
    imem[0] = enc_j(5'd1, 21'h6);
    do_reset();
    rbase = retire_cnt;
    step(); step(); step();
    check("t4_jal_err", {31'b0, err}, 32'd1);
    check("t4_jal_pc", pc, RPC);
    step();
    check("t4_jal_retires", retire_cnt - rbase, 32'd0);
    imem[0] = 32'h0000_0000;
    do_reset();
    step(); step();
    check("t4_ill_pre", {31'b0, err}, 32'd0);
    step();
    check("t4_ill_err", {31'b0, err}, 32'd1);

    // 5: fetch timeout with MAX_WAIT=4, then ack on the last allowed cycle
    clear_prog();
    imem[0] = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'h005);
    imem_en = 1'b0;
    do_reset();
    step(); step(); step(); step();
    check("t5_c4_req", {31'b0, imem_req}, 32'd1);
    check("t5_c4_err", {31'b0, err}, 32'd0);
    step();
    check("t5_c5_err", {31'b0, err}, 32'd1);
    check("t5_c5_req", {31'b0, imem_req}, 32'd0);
    check("t5_pc", pc, RPC);
    imem_en = 1'b1; imem_wait = 3;
    do_reset();
    step(); step(); step(); step();
    check("t5b_c4_ack", {31'b0, imem_ack}, 32'd1);
    step();
    check("t5b_c5_err", {31'b0, err}, 32'd0);
    check("t5b_c5_req", {31'b0, imem_req}, 32'd0);
    wait_halt("t5b_halt");
    check("t5b_final_err", {31'b0, err}, 32'd0);
    imem_wait = 0;

    // 6: EBREAK halt, reset during a pending fetch, restart
    clear_prog();
    do_reset();
    step(); step(); step();
    check("t6_halt", {31'b0, halt}, 32'd1);
    check("t6_reqs", {30'b0, imem_req, dmem_req}, 32'd0);
    check("t6_pc", pc, RPC);
    step(); step(); step();
    check("t6_halt_sticky", {30'b0, halt, retire}, 32'b10);
    imem_en = 1'b0;
    do_reset();
    step();
    check("t6_if_req", {31'b0, imem_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("t6_req_drop", {31'b0, imem_req}, 32'd0);
    imem_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    step();
    check("t6_restart_req", {31'b0, imem_req}, 32'd1);
    check("t6_restart_addr", imem_addr, RPC);
    wait_halt("t6_rehalt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
